// File: rtl/udma_cfg_pkg.sv
// Shared definitions for the uDMA configuration demultiplexer.
//   N_PERIPHS      : default number of peripheral configuration ports
//   CFG_ADDR_W     : upstream byte address width
//   CFG_PER_ADDR_W : register offset width forwarded to peripherals
//   CFG_ID_W       : peripheral ID field width (upper address bits)
//   CFG_ERR_DATA   : read data returned on decode error or timeout
//   cfg_state_e    : demux FSM state encoding
package udma_cfg_pkg;

    localparam int N_PERIPHS      = 4;
    localparam int CFG_ADDR_W     = 12;
    localparam int CFG_PER_ADDR_W = 7;
    localparam int CFG_ID_W       = CFG_ADDR_W - CFG_PER_ADDR_W;

    localparam logic [31:0] CFG_ERR_DATA = 32'hBADACCE5;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        RESP,
        ERR
    } cfg_state_e;

endpackage

// File: rtl/udma_cfg_demux.sv
// uDMA configuration demultiplexer: routes one upstream cfg request at a time
// to the peripheral selected by address bits [11:7], waits for its ready (with
// timeout), and returns a single-cycle response upstream.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for cfg_valid_i; request fields latched on accept
// FWD   | request presented to selected peripheral, timeout running
// RESP  | one-cycle response with captured read data, err = 0
// ERR   | one-cycle error response (bad ID or timeout), err = 1
//
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   cfg_valid_i/addr_i/rwn_i/wdata_i   upstream request
//   cfg_ready_o/rdata_o/err_o    upstream response strobe and payload
//   per_cfg_valid_o              one-hot request to peripherals
//   per_cfg_addr_o/rwn_o/wdata_o latched request fields, shared
//   per_cfg_ready_i/rdata_i      per-peripheral completion and read data
module udma_cfg_demux #(
    parameter int N_PERIPHS = udma_cfg_pkg::N_PERIPHS,
    parameter int TIMEOUT   = 255
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   cfg_valid_i,
    input  logic [11:0]                            cfg_addr_i,
    input  logic                                   cfg_rwn_i,
    input  logic [31:0]                            cfg_wdata_i,
    output logic                                   cfg_ready_o,
    output logic [31:0]                            cfg_rdata_o,
    output logic                                   cfg_err_o,
    output logic [N_PERIPHS-1:0]                   per_cfg_valid_o,
    output logic [udma_cfg_pkg::CFG_PER_ADDR_W-1:0] per_cfg_addr_o,
    output logic                                   per_cfg_rwn_o,
    output logic [31:0]                            per_cfg_wdata_o,
    input  logic [N_PERIPHS-1:0]                   per_cfg_ready_i,
    input  logic [N_PERIPHS*32-1:0]                per_cfg_rdata_i
);

    import udma_cfg_pkg::*;

    // Expiry is detected on the last allowed FWD cycle so that exactly
    // TIMEOUT FWD cycles elapse before ERR.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    cfg_state_e          state_q, state_d;
    logic [CFG_ID_W-1:0] id_q;
    logic [7:0]          cnt_q;
    logic [31:0]         rdata_q;
    logic [31:0]         req_id_ext;
    logic                id_ok;
    logic                expire;
    logic                sel_ready;
    logic [31:0]         sel_rdata;

    assign req_id_ext = {{(32 - CFG_ID_W){1'b0}}, cfg_addr_i[CFG_ADDR_W-1:CFG_PER_ADDR_W]};
    assign id_ok      = (req_id_ext < 32'(N_PERIPHS));
    assign expire     = (cnt_q == TO_LAST);

    // Ready/rdata of the latched peripheral only; other ready bits are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_PERIPHS; i++) begin
            if (id_q == CFG_ID_W'(i)) begin
                sel_ready = per_cfg_ready_i[i];
                sel_rdata = per_cfg_rdata_i[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cfg_valid_i) begin
                    state_d = id_ok ? FWD : ERR;
                end
            end
            FWD: begin
                // Ready on the expiry cycle still completes normally.
                if (sel_ready) begin
                    state_d = RESP;
                end else if (expire) begin
                    state_d = ERR;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_q            <= '0;
            cnt_q           <= '0;
            rdata_q         <= '0;
            per_cfg_addr_o  <= '0;
            per_cfg_rwn_o   <= 1'b0;
            per_cfg_wdata_o <= '0;
        end else begin
            if (state_q == IDLE && cfg_valid_i) begin
                id_q            <= cfg_addr_i[CFG_ADDR_W-1:CFG_PER_ADDR_W];
                cnt_q           <= '0;
                per_cfg_addr_o  <= cfg_addr_i[CFG_PER_ADDR_W-1:0];
                per_cfg_rwn_o   <= cfg_rwn_i;
                per_cfg_wdata_o <= cfg_wdata_i;
            end
            if (state_q == FWD) begin
                if (cnt_q != 8'hFF) begin
                    cnt_q <= cnt_q + 8'd1;
                end
                if (sel_ready) begin
                    rdata_q <= per_cfg_rwn_o ? sel_rdata : 32'h0;
                end
            end
        end
    end

    assign cfg_ready_o = (state_q == RESP) || (state_q == ERR);

    always_comb begin
        cfg_rdata_o = '0;
        cfg_err_o   = 1'b0;
        if (state_q == RESP) begin
            cfg_rdata_o = rdata_q;
        end else if (state_q == ERR) begin
            cfg_rdata_o = CFG_ERR_DATA;
            cfg_err_o   = 1'b1;
        end
    end

    always_comb begin
        per_cfg_valid_o = '0;
        for (int i = 0; i < N_PERIPHS; i++) begin
            per_cfg_valid_o[i] = (state_q == FWD) && (id_q == CFG_ID_W'(i));
        end
    end

endmodule

// File: tb/tb_udma_cfg_demux.sv
// Directed bench for udma_cfg_demux: a reactive peripheral model drives ready
// on a chosen FWD cycle, expected responses go into a scoreboard queue when a
// request is driven and are compared when cfg_ready_o appears.
module tb_udma_cfg_demux;

    localparam int N  = 4;
    localparam int TO = 4;
    localparam logic [31:0] ERR_DATA = 32'hBADACCE5;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cycle;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            cfg_valid;
    logic [11:0]     cfg_addr;
    logic            cfg_rwn;
    logic [31:0]     cfg_wdata;
    logic            cfg_ready;
    logic [31:0]     cfg_rdata;
    logic            cfg_err;
    logic [N-1:0]    per_valid;
    logic [6:0]      per_addr;
    logic            per_rwn;
    logic [31:0]     per_wdata;
    logic [N-1:0]    per_ready;
    logic [N*32-1:0] per_rdata;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    udma_cfg_demux #(
        .N_PERIPHS (N),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cfg_valid_i     (cfg_valid),
        .cfg_addr_i      (cfg_addr),
        .cfg_rwn_i       (cfg_rwn),
        .cfg_wdata_i     (cfg_wdata),
        .cfg_ready_o     (cfg_ready),
        .cfg_rdata_o     (cfg_rdata),
        .cfg_err_o       (cfg_err),
        .per_cfg_valid_o (per_valid),
        .per_cfg_addr_o  (per_addr),
        .per_cfg_rwn_o   (per_rwn),
        .per_cfg_wdata_o (per_wdata),
        .per_cfg_ready_i (per_ready),
        .per_cfg_rdata_i (per_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(cfg_ready), 64'd0);
        check({tag, "_rdata"}, 64'(cfg_rdata), 64'd0);
        check({tag, "_err"},   64'(cfg_err),   64'd0);
        check({tag, "_pvalid"}, 64'(per_valid), 64'd0);
        check({tag, "_paddr"}, 64'(per_addr),  64'd0);
        check({tag, "_prwn"},  64'(per_rwn),   64'd0);
        check({tag, "_pwdata"}, 64'(per_wdata), 64'd0);
    endtask

    // ready_at: FWD cycle (1-based) in which the target raises ready, 0 = never.
    // noise: ready bits of other peripherals held high throughout.
    task automatic run_txn(input string tag, input logic [11:0] addr, input logic rwn,
                           input logic [31:0] wdata, input int ready_at,
                           input logic [31:0] prdata, input logic [N-1:0] noise);
        int           id;
        bit           valid_id;
        logic [N-1:0] oh;
        exp_t         e;
        exp_t         got;
        int           fwd;
        bit           done;

        id       = int'(addr[11:7]);
        valid_id = (id < N);
        oh       = valid_id ? (N'(1) << id) : '0;

        if (!valid_id) begin
            e.rdata = ERR_DATA; e.err = 1'b1; e.cycle = 2;
        end else if (ready_at >= 1 && ready_at <= TO) begin
            e.rdata = rwn ? prdata : 32'h0; e.err = 1'b0; e.cycle = 2 + ready_at;
        end else begin
            e.rdata = ERR_DATA; e.err = 1'b1; e.cycle = 2 + TO;
        end

        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            per_rdata[i*32 +: 32] = 32'h5A5A0000 | 32'(i);
        end
        if (valid_id) per_rdata[id*32 +: 32] = prdata;
        per_ready = noise;
        cfg_valid = 1'b1;
        cfg_addr  = addr;
        cfg_rwn   = rwn;
        cfg_wdata = wdata;
        sb.push_back(e);

        fwd  = 0;
        done = 0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(posedge clk); #1;
            if (cfg_ready) begin
                check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    got = sb.pop_front();
                    check({tag, "_rdata"}, 64'(cfg_rdata), 64'(got.rdata));
                    check({tag, "_err"},   64'(cfg_err),   64'(got.err));
                    check({tag, "_cycle"}, 64'(cyc + 1),   64'(got.cycle));
                end
                check({tag, "_pvalid_resp"}, 64'(per_valid), 64'd0);
                cfg_valid = 1'b0;
                per_ready = '0;
                done      = 1;
            end else begin
                check({tag, "_idle_payload"}, {31'd0, cfg_err, cfg_rdata}, 64'd0);
                check({tag, "_pvalid"}, 64'(per_valid), 64'(oh));
                if (valid_id) begin
                    check({tag, "_paddr"},  64'(per_addr),  64'(addr[6:0]));
                    check({tag, "_prwn"},   64'(per_rwn),   64'(rwn));
                    check({tag, "_pwdata"}, 64'(per_wdata), 64'(wdata));
                end
                fwd++;
                per_ready = noise | ((valid_id && fwd == ready_at) ? oh : '0);
            end
        end
        if (!done) begin
            check({tag, "_response_seen"}, 64'd0, 64'd1);
            cfg_valid = 1'b0;
            per_ready = '0;
        end
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_addr  = '0;
        cfg_rwn   = 1'b0;
        cfg_wdata = '0;
        per_ready = '0;
        per_rdata = '0;

        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Write, ID 1 offset 0x04, ready in second FWD cycle; write returns 0 data.
        run_txn("wr_id1", 12'h084, 1'b0, 32'hA5A5A5A5, 2, 32'hDEADBEEF, '0);
        // Read, ID 3, immediate ready.
        run_txn("rd_id3", 12'h188, 1'b1, 32'h0, 1, 32'h12345678, '0);
        // Out-of-range ID 4.
        run_txn("rd_id4", 12'h200, 1'b1, 32'h0, 1, 32'h0, '0);
        // Highest ID 31.
        run_txn("rd_id31", 12'hF80, 1'b0, 32'h11111111, 1, 32'h0, '0);
        // ID 0, never ready: timeout after TO FWD cycles.
        run_txn("timeout", 12'h000, 1'b1, 32'h0, 0, 32'hCAFEF00D, '0);
        // Ready on the expiry cycle wins.
        run_txn("ready_at_expiry", 12'h010, 1'b1, 32'h0, TO, 32'h0BAD0001, '0);
        // Stray ready on bit 2 while targeting ID 0 is ignored.
        run_txn("stray_ready", 12'h000, 1'b1, 32'h0, 3, 32'h87654321, 4'b0100);
        // Read ID 2 with offset 0x7F.
        run_txn("rd_id2", 12'h17F, 1'b1, 32'h0, 1, 32'hF00DCAFE, '0);

        // Reset pulsed mid-FWD: outputs clear at once, no late response.
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_addr  = 12'h0C8;
        cfg_rwn   = 1'b0;
        cfg_wdata = 32'h13572468;
        @(posedge clk); #1;
        check("abort_pvalid_fwd", 64'(per_valid), 64'h2);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_all_zero("abort_rst");
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        rst       = 1'b0;
        per_ready = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("abort_no_ready", 64'(cfg_ready), 64'd0);
        end
        per_ready = '0;

        run_txn("after_abort", 12'h0C8, 1'b1, 32'h0, 2, 32'h2468ACE0, '0);

        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/udma_cfg_demux.md
UDMA_CFG_DEMUX -- requirements
Module: udma_cfg_demux

Interface
REQ-001 SHALL have parameter N_PERIPHS, default udma_cfg_pkg::N_PERIPHS (4), number of peripheral cfg ports.
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles waiting for peripheral ready (range 1..255).
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk_i  input  1  clock, all state on rising edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 cfg_valid_i  input  1  upstream request valid; held until cfg_ready_o.
REQ-007 cfg_addr_i  input  12  byte address; [11:7] peripheral ID, [6:0] register offset.
REQ-008 cfg_rwn_i  input  1  1 = read, 0 = write.
REQ-009 cfg_wdata_i  input  32  write data.
REQ-010 cfg_ready_o  output  1  one-cycle response strobe.
REQ-011 cfg_rdata_o  output  32  read data, valid with cfg_ready_o.
REQ-012 cfg_err_o  output  1  error flag, valid with cfg_ready_o.
REQ-013 per_cfg_valid_o  output  N_PERIPHS  one-hot request to peripheral.
REQ-014 per_cfg_addr_o  output  7  latched register offset, shared.
REQ-015 per_cfg_rwn_o  output  1  latched rwn, shared.
REQ-016 per_cfg_wdata_o  output  32  latched write data, shared.
REQ-017 per_cfg_ready_i  input  N_PERIPHS  per-peripheral completion.
REQ-018 per_cfg_rdata_i  input  N_PERIPHS x 32  per-peripheral read data.

Function
REQ-019 FSM states SHALL be IDLE, FWD, RESP, ERR.
REQ-020 IDLE: on cfg_valid_i, latch addr offset, rwn, wdata, ID; go FWD if ID < N_PERIPHS, else ERR.
REQ-021 FWD: per_cfg_valid_o[ID] SHALL be 1, all other bits 0; timeout counter increments each FWD cycle.
REQ-022 FWD: when per_cfg_ready_i[ID]=1, rdata SHALL be captured (writes capture 0), err=0, go RESP.
REQ-023 FWD: when counter reaches TIMEOUT without ready, go ERR; ready in the same cycle as expiry wins (RESP).
REQ-024 RESP/ERR: cfg_ready_o SHALL be 1 for exactly one cycle, then return to IDLE.
REQ-025 ERR: cfg_rdata_o SHALL be udma_cfg_pkg::CFG_ERR_DATA (32'hBADACCE5), cfg_err_o=1.
REQ-026 cfg_rdata_o/cfg_err_o SHALL be 0 whenever cfg_ready_o=0.
REQ-027 Minimum latency SHALL be 3 cycles from accept edge to cfg_ready_o (IDLE, FWD, RESP), ready in first FWD cycle.
REQ-028 cfg_valid_i during FWD/RESP/ERR SHALL be ignored; next request accepted only in IDLE.
REQ-029 per_cfg_ready_i bits not matching latched ID SHALL be ignored.
REQ-030 Shared per_cfg_* data outputs SHALL stay stable for the whole FWD phase.
REQ-031 Timeout counter SHALL be 8 bits, cleared on every IDLE-to-FWD transition, never wrap.

Reset
REQ-032 rst_i=1 SHALL force IDLE, counter 0, all outputs 0, asynchronously, including mid-FWD.
REQ-033 An aborted transaction SHALL not produce cfg_ready_o after reset release.

Structure
REQ-034 udma_cfg_pkg SHALL hold CFG_PER_ADDR_W (7), CFG_ERR_DATA, and the FSM state typedef.
REQ-035 Single module, no sub-modules; ID decode and rdata mux inline.

Verification
REQ-036 Write addr 0x084 (ID 1, off 0x04), wdata 0xA5A5A5A5, ready after 2 cycles -> per_cfg_valid_o=4'b0010, off 0x04, cfg_ready_o at cycle 4, err 0.
REQ-037 Read addr 0x188 (ID 3), per_cfg_rdata_i[3]=0x12345678, immediate ready -> cfg_rdata_o=0x12345678, latency 3.
REQ-038 Read addr 0x200 (ID 4 >= 4) -> no per_cfg_valid_o, cfg_ready_o at cycle 2, rdata 0xBADACCE5, err 1.
REQ-039 ID 0, peripheral never ready, TIMEOUT=4 -> ERR response after 4 FWD cycles, err 1.
REQ-040 rst_i pulsed in FWD -> all outputs 0 immediately, no later cfg_ready_o; next request completes normally.
REQ-041 per_cfg_ready_i[2]=1 while targeting ID 0 -> ignored, transaction waits for bit 0.
